// File: rtl/seg7_scan_if.sv
// Scanned seven-segment bus plus the frame results recovered from it.
interface seg7_scan_if;
  logic [6:0]  seg7_7bit;
  logic [3:0]  seg7_an;
  logic        seg7_dp;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic [3:0]  err_mask;
  logic        frame_valid;
  logic        frame_stb;
  logic        digit_err;
  logic        timeout;

  modport master (
    output seg7_7bit, seg7_an, seg7_dp,
    input  value, dp_mask, blank_mask, err_mask,
    input  frame_valid, frame_stb, digit_err, timeout
  );

  modport slave (
    input  seg7_7bit, seg7_an, seg7_dp,
    output value, dp_mask, blank_mask, err_mask,
    output frame_valid, frame_stb, digit_err, timeout
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// Decodes a multiplexed 4-digit seven-segment bus back into a 16-bit value,
// capturing each digit once it has been stable for SETTLE_CYCLES samples.
module seg7_scan_capture #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned FRAME_TIMEOUT = 1000000,
  parameter bit          SEG_ACT_HIGH  = 1'b1,
  parameter bit          AN_ACT_HIGH   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  seg7_scan_if.slave  bus
);
  localparam int unsigned CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned IDLE_W = $clog2(FRAME_TIMEOUT + 1);
  localparam int unsigned SMP_W  = 12;

  typedef enum logic [1:0] {IDLE, SETTLING, HELD} state_t;

  state_t             state_q, state_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [SMP_W-1:0]   cmp_q, cmp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [15:0]        stage_val_q, stage_val_d;
  logic [3:0]         stage_dp_q, stage_dp_d;
  logic [3:0]         stage_blank_q, stage_blank_d;
  logic [3:0]         stage_err_q, stage_err_d;
  logic [3:0]         seen_q, seen_d;
  logic [15:0]        value_q, value_d;
  logic [3:0]         dp_mask_q, dp_mask_d;
  logic [3:0]         blank_mask_q, blank_mask_d;
  logic [3:0]         err_mask_q, err_mask_d;
  logic               frame_valid_q, frame_valid_d;
  logic               frame_stb_q, frame_stb_d;
  logic               digit_err_q, digit_err_d;
  logic               timeout_q, timeout_d;

  logic [SMP_W-1:0]   sample;
  logic               sample_valid;
  logic               capture;
  logic               publish;
  logic [4:0]         decoded;
  logic               is_blank;
  logic               is_err;

  // Returns {known, nibble}; unknown patterns report nibble 0.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'h3F: return 5'h10;
      7'h06: return 5'h11;
      7'h5B: return 5'h12;
      7'h4F: return 5'h13;
      7'h66: return 5'h14;
      7'h6D: return 5'h15;
      7'h7D: return 5'h16;
      7'h07: return 5'h17;
      7'h7F: return 5'h18;
      7'h6F: return 5'h19;
      7'h77: return 5'h1A;
      7'h7C: return 5'h1B;
      7'h39: return 5'h1C;
      7'h5E: return 5'h1D;
      7'h79: return 5'h1E;
      7'h71: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  // Input normalisation; the decimal point shares the segment polarity.
  always_comb begin
    an_d  = AN_ACT_HIGH  ? bus.seg7_an   : ~bus.seg7_an;
    seg_d = SEG_ACT_HIGH ? bus.seg7_7bit : ~bus.seg7_7bit;
    dp_d  = SEG_ACT_HIGH ? bus.seg7_dp   : ~bus.seg7_dp;
  end

  // Settle tracker: a digit must repeat identically before it is captured.
  always_comb begin
    sample       = {an_q, seg_q, dp_q};
    sample_valid = (an_q != 4'd0) && ((an_q & (an_q - 4'd1)) == 4'd0);
    state_d      = state_q;
    cmp_d        = cmp_q;
    cnt_d        = cnt_q;
    capture      = 1'b0;
    case (state_q)
      SETTLING: begin
        if (sample == cmp_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == CNT_W'(SETTLE_CYCLES)) begin
            capture = 1'b1;
            state_d = HELD;
          end
        end else if (sample_valid) begin
          cmp_d = sample;
          cnt_d = CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      HELD: begin
        if (sample != cmp_q) begin
          if (sample_valid) begin
            cmp_d   = sample;
            cnt_d   = CNT_W'(1);
            state_d = SETTLING;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        if (sample_valid) begin
          cmp_d   = sample;
          cnt_d   = CNT_W'(1);
          state_d = SETTLING;
        end
      end
    endcase
  end

  // Staging, frame publish and partial-frame timeout.
  always_comb begin
    decoded       = decode_seg(seg_q);
    is_blank      = (seg_q == 7'd0);
    is_err        = !decoded[4] && !is_blank;
    publish       = (seen_q == 4'hF);
    stage_val_d   = stage_val_q;
    stage_dp_d    = stage_dp_q;
    stage_blank_d = stage_blank_q;
    stage_err_d   = stage_err_q;
    seen_d        = publish ? 4'd0 : seen_q;
    value_d       = value_q;
    dp_mask_d     = dp_mask_q;
    blank_mask_d  = blank_mask_q;
    err_mask_d    = err_mask_q;
    frame_valid_d = frame_valid_q;
    frame_stb_d   = 1'b0;
    digit_err_d   = capture && is_err;
    timeout_d     = 1'b0;
    idle_d        = idle_q;

    if (publish) begin
      value_d       = stage_val_q;
      dp_mask_d     = stage_dp_q;
      blank_mask_d  = stage_blank_q;
      err_mask_d    = stage_err_q;
      frame_stb_d   = 1'b1;
      frame_valid_d = 1'b1;
    end

    if (capture) begin
      for (int i = 0; i < 4; i++) begin
        if (an_q[i]) begin
          stage_val_d[4*i +: 4] = decoded[3:0];
          stage_blank_d[i]      = is_blank;
          stage_err_d[i]        = is_err;
          stage_dp_d[i]         = dp_q;
          seen_d[i]             = 1'b1;
        end
      end
    end

    // Counter only runs while a partial frame is pending.
    if (capture) begin
      idle_d = '0;
    end else if (seen_q != 4'd0 && idle_q != IDLE_W'(FRAME_TIMEOUT)) begin
      idle_d = idle_q + IDLE_W'(1);
    end

    if (!capture && !publish && seen_q != 4'd0 &&
        idle_q + IDLE_W'(1) == IDLE_W'(FRAME_TIMEOUT)) begin
      seen_d        = 4'd0;
      frame_valid_d = 1'b0;
      timeout_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      an_q          <= '0;
      seg_q         <= '0;
      dp_q          <= 1'b0;
      cmp_q         <= '0;
      cnt_q         <= '0;
      idle_q        <= '0;
      stage_val_q   <= '0;
      stage_dp_q    <= '0;
      stage_blank_q <= '0;
      stage_err_q   <= '0;
      seen_q        <= '0;
      value_q       <= '0;
      dp_mask_q     <= '0;
      blank_mask_q  <= '0;
      err_mask_q    <= '0;
      frame_valid_q <= 1'b0;
      frame_stb_q   <= 1'b0;
      digit_err_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      cmp_q         <= cmp_d;
      cnt_q         <= cnt_d;
      idle_q        <= idle_d;
      stage_val_q   <= stage_val_d;
      stage_dp_q    <= stage_dp_d;
      stage_blank_q <= stage_blank_d;
      stage_err_q   <= stage_err_d;
      seen_q        <= seen_d;
      value_q       <= value_d;
      dp_mask_q     <= dp_mask_d;
      blank_mask_q  <= blank_mask_d;
      err_mask_q    <= err_mask_d;
      frame_valid_q <= frame_valid_d;
      frame_stb_q   <= frame_stb_d;
      digit_err_q   <= digit_err_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.dp_mask     = dp_mask_q;
  assign bus.blank_mask  = blank_mask_q;
  assign bus.err_mask    = err_mask_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_stb   = frame_stb_q;
  assign bus.digit_err   = digit_err_q;
  assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: directed scenarios, then random frames scored
// against a dwell-level model of the digit capture rules.
module tb_seg7_scan_capture;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned TMO    = 100;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_if bus();

  seg7_scan_capture #(
    .SETTLE_CYCLES(SETTLE), .FRAME_TIMEOUT(TMO),
    .SEG_ACT_HIGH(1'b1), .AN_ACT_HIGH(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Pulse monitor, sampled on the inactive edge.
  int cyc = 0, n_stb = 0, n_err = 0, n_tmo = 0;
  int last_err_cyc = 0, last_tmo_cyc = 0;
  always @(negedge clk) begin
    cyc++;
    if (bus.frame_stb === 1'b1) n_stb++;
    if (bus.digit_err === 1'b1) begin n_err++; last_err_cyc = cyc; end
    if (bus.timeout === 1'b1) begin n_tmo++; last_tmo_cyc = cyc; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int n);
    bus.seg7_an   = an;
    bus.seg7_7bit = seg;
    bus.seg7_dp   = dp;
    repeat (n) @(negedge clk);
  endtask

  // {err, blank, nibble} straight from the digit table.
  function automatic logic [5:0] ref_decode(input logic [6:0] s);
    if (s == 7'h00) return 6'b01_0000;
    for (int v = 0; v < 16; v++)
      if (SEG_TABLE[v] == s) return {2'b00, 4'(v)};
    return 6'b10_0000;
  endfunction

  int s_stb, s_err, s_tmo, exp_err, nocap, kind, slot, len, r;
  logic [3:0]  an, m_seen, m_dp, m_bl, m_er;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] m_val;
  logic [11:0] key, prev;
  logic [5:0]  dec;

  initial begin
    dwell(4'd0, 7'd0, 1'b0, 3);
    check("rst_value", 32'(bus.value), 32'h0);
    check("rst_valid", 32'(bus.frame_valid), 32'h0);
    check("rst_masks", 32'({bus.dp_mask, bus.blank_mask, bus.err_mask}), 32'h0);
    check("rst_pulses", 32'({bus.frame_stb, bus.digit_err, bus.timeout}), 32'h0);
    rst = 1'b0;
    dwell(4'd0, 7'd0, 1'b0, 2);

    // Basic frame 4321.
    s_stb = n_stb;
    dwell(4'b0001, 7'h06, 1'b0, 8);
    dwell(4'b0010, 7'h5B, 1'b0, 8);
    dwell(4'b0100, 7'h4F, 1'b0, 8);
    dwell(4'b1000, 7'h66, 1'b0, 8);
    dwell(4'd0, 7'd0, 1'b0, 4);
    check("basic_stb", 32'(n_stb - s_stb), 32'd1);
    check("basic_value", 32'(bus.value), 32'h4321);
    check("basic_valid", 32'(bus.frame_valid), 32'h1);
    check("basic_masks", 32'({bus.dp_mask, bus.blank_mask, bus.err_mask}), 32'h0);

    // Error, blank and decimal point.
    s_stb = n_stb; s_err = n_err;
    dwell(4'b0001, 7'h6D, 1'b0, 8);
    dwell(4'b0010, 7'h7D, 1'b1, 8);
    dwell(4'b0100, 7'h01, 1'b0, 8);
    dwell(4'b1000, 7'h00, 1'b0, 8);
    dwell(4'd0, 7'd0, 1'b0, 4);
    check("eb_stb", 32'(n_stb - s_stb), 32'd1);
    check("eb_digit_err", 32'(n_err - s_err), 32'd1);
    check("eb_value", 32'(bus.value), 32'h0065);
    check("eb_err_mask", 32'(bus.err_mask), 32'h4);
    check("eb_blank_mask", 32'(bus.blank_mask), 32'h8);
    check("eb_dp_mask", 32'(bus.dp_mask), 32'h2);

    // Reset asserted mid-cycle with two slots pending.
    dwell(4'b0001, 7'h06, 1'b0, 8);
    dwell(4'b0010, 7'h5B, 1'b0, 8);
    #2 rst = 1'b1;
    #1;
    check("mrst_value", 32'(bus.value), 32'h0);
    check("mrst_valid", 32'(bus.frame_valid), 32'h0);
    check("mrst_masks", 32'({bus.dp_mask, bus.blank_mask, bus.err_mask}), 32'h0);
    dwell(4'd0, 7'd0, 1'b0, 2);
    rst = 1'b0;
    dwell(4'd0, 7'd0, 1'b0, 2);

    // Short glitch on slot 0 must not be captured.
    s_stb = n_stb;
    dwell(4'b0001, 7'h7F, 1'b0, 3);
    dwell(4'b0001, 7'h06, 1'b0, 8);
    dwell(4'b0010, 7'h5B, 1'b0, 8);
    dwell(4'b0100, 7'h4F, 1'b0, 8);
    dwell(4'b1000, 7'h66, 1'b0, 8);
    dwell(4'd0, 7'd0, 1'b0, 4);
    check("glitch_stb", 32'(n_stb - s_stb), 32'd1);
    check("glitch_value", 32'(bus.value), 32'h4321);
    check("glitch_masks", 32'({bus.dp_mask, bus.blank_mask, bus.err_mask}), 32'h0);

    // Invalid anodes between captures leave the pending slots intact.
    s_stb = n_stb; s_err = n_err;
    dwell(4'b0001, 7'h3F, 1'b0, 8);
    dwell(4'b0010, 7'h06, 1'b0, 8);
    dwell(4'b0011, 7'h01, 1'b0, 20);
    dwell(4'b0000, 7'h02, 1'b0, 20);
    check("badan_stb", 32'(n_stb - s_stb), 32'd0);
    check("badan_digit_err", 32'(n_err - s_err), 32'd0);
    dwell(4'b0100, 7'h5B, 1'b0, 8);
    dwell(4'b1000, 7'h4F, 1'b0, 8);
    dwell(4'd0, 7'd0, 1'b0, 4);
    check("badan_frame_stb", 32'(n_stb - s_stb), 32'd1);
    check("badan_value", 32'(bus.value), 32'h3210);

    // Partial frame times out TMO cycles after its last capture.
    s_err = n_err; s_tmo = n_tmo;
    dwell(4'b0001, 7'h77, 1'b0, 8);
    dwell(4'b0010, 7'h02, 1'b0, 8);
    dwell(4'd0, 7'd0, 1'b0, 400);
    check("tmo_digit_err", 32'(n_err - s_err), 32'd1);
    check("tmo_count", 32'(n_tmo - s_tmo), 32'd1);
    check("tmo_delay", 32'(last_tmo_cyc - last_err_cyc), 32'(TMO));
    check("tmo_valid", 32'(bus.frame_valid), 32'h0);
    check("tmo_value", 32'(bus.value), 32'h3210);

    // Random frames against the dwell-level model.
    m_val = '0; m_dp = '0; m_bl = '0; m_er = '0;
    prev = 12'hFFF;
    for (int f = 0; f < 25; f++) begin
      s_stb = n_stb; s_err = n_err;
      m_seen = '0; exp_err = 0; nocap = 0;
      while (m_seen != 4'hF) begin
        kind = (nocap >= 3) ? 0 : int'($urandom_range(0, 5));
        slot = int'($urandom_range(0, 3));
        an   = 4'(1 << slot);
        r    = int'($urandom_range(0, 99));
        seg  = (r < 70) ? SEG_TABLE[$urandom_range(0, 15)] : (r < 85) ? 7'h00 : 7'($urandom);
        dp   = 1'($urandom);
        if (kind == 5) begin
          do an = 4'($urandom_range(0, 15)); while ($countones(an) == 1);
          len = int'($urandom_range(1, 12));
        end else if (kind >= 3) begin
          len = int'($urandom_range(1, SETTLE - 1));
        end else begin
          len = int'($urandom_range(SETTLE, 10));
        end
        key = {an, seg, dp};
        if (key == prev) dwell(4'd0, 7'd0, 1'b0, 1);
        dwell(an, seg, dp, len);
        prev = key;
        if (kind <= 2) begin
          dec = ref_decode(seg);
          m_val[4*slot +: 4] = dec[3:0];
          m_bl[slot]   = dec[4];
          m_er[slot]   = dec[5];
          m_dp[slot]   = dp;
          m_seen[slot] = 1'b1;
          if (dec[5]) exp_err++;
          nocap = 0;
        end else begin
          nocap++;
        end
      end
      dwell(4'd0, 7'd0, 1'b0, 5);
      prev = 12'h000;
      check("rnd_stb", 32'(n_stb - s_stb), 32'd1);
      check("rnd_digit_err", 32'(n_err - s_err), 32'(exp_err));
      check("rnd_value", 32'(bus.value), 32'(m_val));
      check("rnd_dp_mask", 32'(bus.dp_mask), 32'(m_dp));
      check("rnd_blank_mask", 32'(bus.blank_mask), 32'(m_bl));
      check("rnd_err_mask", 32'(bus.err_mask), 32'(m_er));
      check("rnd_valid", 32'(bus.frame_valid), 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
